// File: rtl/inference_pkg.sv
// Shared types and constants for the inference pipeline sequencer.
// Stage indices follow the order in which the network layers are chained.
package inference_pkg;

  localparam int DEF_NUM_STAGES = 7;
  localparam int DEF_CNT_WIDTH  = 24;

  localparam int STG_INPUT  = 0;
  localparam int STG_FC1    = 1;
  localparam int STG_TANH1  = 2;
  localparam int STG_FC2    = 3;
  localparam int STG_TANH2  = 4;
  localparam int STG_FC3    = 5;
  localparam int STG_OUTPUT = 6;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_FINISH = 2'd3
  } seq_state_t;

endpackage

// File: rtl/inference_sequencer_sat_counter.sv
// Saturating up-counter: clear wins over enable, and the count sticks at all-ones.
module sat_counter #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && !(&cnt))    cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/inference_sequencer.sv
// Launches the enabled pipeline stages one after another, timing each stage and
// the whole run. A run that executes stages completes in its last stage_done cycle.
module inference_sequencer
  import inference_pkg::*;
#(
  parameter int          NUM_STAGES     = DEF_NUM_STAGES,
  parameter int          CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 2**CNT_WIDTH-1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [NUM_STAGES-1:0]                bypass_mask,
  output logic [NUM_STAGES-1:0]                stage_start,
  input  logic [NUM_STAGES-1:0]                stage_done,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 error,
  output logic [$clog2(NUM_STAGES)-1:0]        cur_stage,
  output logic [NUM_STAGES-1:0][CNT_WIDTH-1:0] stage_cycles,
  output logic [CNT_WIDTH-1:0]                 total_cycles
);

  localparam int SW = $clog2(NUM_STAGES);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  // {found, index} of the lowest non-bypassed stage at or above 'from'
  function automatic logic [SW:0] first_free(input logic [NUM_STAGES-1:0] mask,
                                             input int from);
    logic [SW:0] r;
    r = '0;
    for (int k = NUM_STAGES-1; k >= 0; k--)
      if (k >= from && !mask[k]) r = {1'b1, SW'(k)};
    return r;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  seq_state_t                           state_q, state_d;
  logic [SW-1:0]                        cur_q, cur_d;
  logic [NUM_STAGES-1:0]                run_mask_q, run_mask_d;
  logic [NUM_STAGES-1:0]                pend_mask_q, pend_mask_d;
  logic                                 pend_q, pend_d;
  logic                                 err_q, err_d;
  logic [NUM_STAGES-1:0][CNT_WIDTH-1:0] stage_cyc_q;
  logic [CNT_WIDTH-1:0]                 total_q;

  logic                  done_c, new_run, lat_stage;
  logic                  stage_hit, run_req;
  logic [NUM_STAGES-1:0] new_mask;
  logic [SW:0]           first_sel, next_sel;
  logic [CNT_WIDTH-1:0]  wait_cnt, stg_cnt, tot_cnt;

  // pend_q is never set in IDLE, so a fresh start always uses bypass_mask
  assign new_mask  = pend_q ? pend_mask_q : bypass_mask;
  assign first_sel = first_free(new_mask, 0);
  assign next_sel  = first_free(run_mask_q, int'(cur_q) + 1);
  assign stage_hit = (state_q == S_WAIT) && stage_done[cur_q];
  assign run_req   = pend_q || start;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    run_mask_d  = run_mask_q;
    pend_d      = pend_q;
    pend_mask_d = pend_mask_q;
    err_d       = err_q;
    done_c      = 1'b0;
    new_run     = 1'b0;
    lat_stage   = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      pend_d  = 1'b0;
    end else begin
      if (state_q != S_IDLE && start && !pend_q) begin
        pend_d      = 1'b1;
        pend_mask_d = bypass_mask;
      end

      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            new_run = 1'b1;
            err_d   = 1'b0;
          end
        end
        S_LAUNCH: state_d = S_WAIT;
        S_WAIT: begin
          if (stage_hit) begin
            lat_stage = 1'b1;
            if (next_sel[SW]) begin
              cur_d   = next_sel[SW-1:0];
              state_d = S_LAUNCH;
            end else begin
              done_c = 1'b1;
              if (run_req) new_run = 1'b1;
              else         state_d = S_IDLE;
            end
          end else if (wait_cnt == TMO_LAST) begin
            err_d   = 1'b1;
            pend_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
        S_FINISH: begin
          done_c = 1'b1;
          if (run_req) new_run = 1'b1;
          else         state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      // Accepting or dispatching a run: the mask is frozen here for its whole life
      if (new_run) begin
        run_mask_d = new_mask;
        pend_d     = 1'b0;
        if (first_sel[SW]) begin
          cur_d   = first_sel[SW-1:0];
          state_d = S_LAUNCH;
        end else begin
          state_d = S_FINISH;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      run_mask_q  <= '0;
      pend_mask_q <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      stage_cyc_q <= '0;
      total_q     <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      run_mask_q  <= run_mask_d;
      pend_mask_q <= pend_mask_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      if (done_c) total_q <= sat_inc(tot_cnt);
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (new_run && new_mask[k])                stage_cyc_q[k] <= '0;
        else if (lat_stage && cur_q == SW'(k))     stage_cyc_q[k] <= sat_inc(stg_cnt);
      end
    end
  end

  // Counts cycles since stage_start, so it reads TIMEOUT_CYCLES-1 on the last WAIT cycle
  sat_counter #(.W(CNT_WIDTH)) u_wait_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_d != S_WAIT),
    .en    (state_q == S_LAUNCH || state_q == S_WAIT),
    .cnt   (wait_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_stage_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q == S_LAUNCH),
    .en    (state_q == S_WAIT),
    .cnt   (stg_cnt)
  );

  sat_counter #(.W(CNT_WIDTH)) u_total_tmr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (new_run),
    .en    (busy),
    .cnt   (tot_cnt)
  );

  always_comb begin
    stage_start = '0;
    if (state_q == S_LAUNCH) stage_start[cur_q] = 1'b1;
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = done_c;
  assign error        = err_q;
  assign cur_stage    = cur_q;
  assign stage_cycles = stage_cyc_q;
  assign total_cycles = total_q;

endmodule

// File: tb/tb_inference_sequencer.sv
// Directed bench for inference_sequencer: a stage responder answers each launch
// after a programmable latency, and a monitor logs event cycles relative to start.
module tb_inference_sequencer;

  localparam int NS = 7;
  localparam int CW = 24;

  logic               clk;
  logic               rst_n, start, abort;
  logic [NS-1:0]      bypass_mask, stage_start, stage_done;
  logic               busy, done, error;
  logic [2:0]         cur_stage;
  logic [NS-1:0][CW-1:0] stage_cycles;
  logic [CW-1:0]      total_cycles;

  inference_sequencer #(.NUM_STAGES(NS), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(100)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .bypass_mask  (bypass_mask),
    .stage_start  (stage_start),
    .stage_done   (stage_done),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cur_stage    (cur_stage),
    .stage_cycles (stage_cycles),
    .total_cycles (total_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Stage responder: stage_done[k] arrives 'lat' cycles after stage_start[k]
  int            lat = 5;
  logic [NS-1:0] hang = '0;
  int            due [NS];
  initial begin
    stage_done = '0;
    for (int k = 0; k < NS; k++) due[k] = -1;
  end
  always @(posedge clk) begin
    #1;
    stage_done = '0;
    for (int k = 0; k < NS; k++) begin
      if (due[k] == cyc) begin
        stage_done[k] = 1'b1;
        due[k] = -1;
      end
      if (stage_start[k] && !hang[k]) due[k] = cyc + lat;
    end
  end

  // Monitor: event cycles relative to the cycle start was driven
  int ss_cnt [NS];
  int ss_first [NS];
  int ss_last [NS];
  int done_cnt, done_first, done_last, busy_cnt, last_busy, err_rise;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NS; k++)
        if (stage_start[k]) begin
          if (ss_cnt[k] == 0) ss_first[k] = cyc - base;
          ss_last[k] = cyc - base;
          ss_cnt[k]++;
        end
      if (done) begin
        if (done_cnt == 0) done_first = cyc - base;
        done_last = cyc - base;
        done_cnt++;
      end
      if (busy) begin
        busy_cnt++;
        last_busy = cyc - base;
      end
      if (error && err_rise < 0) err_rise = cyc - base;
    end
  end

  task automatic clear_mon();
    for (int k = 0; k < NS; k++) begin
      ss_cnt[k] = 0; ss_first[k] = -1; ss_last[k] = -1;
    end
    done_cnt = 0; done_first = -1; done_last = -1;
    busy_cnt = 0; last_busy = -1; err_rise = -1;
  endtask

  task automatic step_to(input int rel);
    while (cyc - base < rel) begin
      @(posedge clk); #1;
    end
  endtask

  // Drives start for exactly one cycle; that cycle is relative cycle 0
  task automatic begin_run(input logic [NS-1:0] mask);
    @(posedge clk); #1;
    clear_mon();
    base        = cyc;
    bypass_mask = mask;
    start       = 1'b1;
    @(posedge clk); #1;
    start       = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; bypass_mask = '0;
    clear_mon();
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_stage_start", stage_start, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_cur_stage", cur_stage, 0);
    chk("rst_total", total_cycles, 0);
    chk("rst_stage_cycles_any", {63'd0, |stage_cycles}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end

    // Full run, no bypass, 5-cycle stages
    lat = 5;
    begin_run(7'b0000000);
    step_to(50);
    chk("t1_ss0_cycle", ss_first[0], 1);
    chk("t1_ss6_cycle", ss_first[6], 37);
    chk("t1_done_cycle", done_first, 42);
    chk("t1_done_count", done_cnt, 1);
    chk("t1_total", total_cycles, 42);
    chk("t1_last_busy", last_busy, 42);
    chk("t1_cur_stage_hold", cur_stage, 6);
    for (int k = 0; k < NS; k++)
      chk($sformatf("t1_stage_cycles_%0d", k), stage_cycles[k], 5);

    // Odd stages bypassed, 3-cycle stages
    lat = 3;
    begin_run(7'b0101010);
    step_to(30);
    chk("t2_bypassed_launches", ss_cnt[1] + ss_cnt[3] + ss_cnt[5], 0);
    chk("t2_ss2_cycle", ss_first[2], 5);
    chk("t2_ss6_cycle", ss_first[6], 13);
    chk("t2_done_cycle", done_first, 16);
    chk("t2_stage_cycles_1", stage_cycles[1], 0);
    chk("t2_stage_cycles_2", stage_cycles[2], 3);
    chk("t2_total", total_cycles, 16);

    // Every stage bypassed
    begin_run(7'h7F);
    step_to(10);
    chk("t3_done_cycle", done_first, 1);
    chk("t3_done_count", done_cnt, 1);
    chk("t3_busy_cycles", busy_cnt, 1);
    chk("t3_launches", ss_cnt[0] + ss_cnt[2] + ss_cnt[4] + ss_cnt[6], 0);
    chk("t3_total", total_cycles, 1);

    // Stage 3 never answers: timeout 100 cycles after its launch
    lat = 5;
    hang = 7'b0001000;
    begin_run(7'b0000000);
    step_to(130);
    chk("t4_ss3_cycle", ss_first[3], 19);
    chk("t4_error_rise", err_rise, 119);
    chk("t4_last_busy", last_busy, 118);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_error_sticky", error, 1);
    hang = '0;
    begin_run(7'h7F);
    step_to(5);
    chk("t4_error_cleared", error, 0);
    chk("t4_rerun_done", done_cnt, 1);

    // Abort coincident with stage_done[2]
    lat = 5;
    begin_run(7'b0000000);
    step_to(18);
    abort = 1'b1;
    step_to(19);
    abort = 1'b0;
    step_to(40);
    chk("t5_no_ss3", ss_cnt[3], 0);
    chk("t5_no_done", done_cnt, 0);
    chk("t5_last_busy", last_busy, 18);
    chk("t5_stage_cycles_1", stage_cycles[1], 5);
    chk("t5_stage_cycles_2_unlatched", stage_cycles[2], 0);

    // Two starts during a run: one back-to-back rerun
    lat = 2;
    begin_run(7'b0000000);
    step_to(5);  start = 1'b1;
    step_to(6);  start = 1'b0;
    step_to(10); start = 1'b1;
    step_to(11); start = 1'b0;
    step_to(55);
    chk("t6_done_count", done_cnt, 2);
    chk("t6_first_done", done_first, 21);
    chk("t6_second_done", done_last, 42);
    chk("t6_ss0_count", ss_cnt[0], 2);
    chk("t6_ss0_rerun_cycle", ss_last[0], 22);
    chk("t6_total", total_cycles, 21);

    // Reset in the middle of stage 1
    lat = 5;
    begin_run(7'b0000000);
    step_to(10);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_total", total_cycles, 0);
    chk("t7_rst_stage_cycles_any", {63'd0, |stage_cycles}, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    step_to(30);
    chk("t7_no_done", done_cnt, 0);
    chk("t7_launches", ss_cnt[0] + ss_cnt[1], 2);
    chk("t7_no_ss2", ss_cnt[2], 0);
    chk("t7_busy_cycles", busy_cnt, 9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
